// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for RV32M DIV/DIVU/REM/REMU
// One quotient bit per CALC cycle; divide-by-zero and signed overflow bypass to DONE.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITERS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic [1:0]      op_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] special_res;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] final_res;

  // Operand preparation and special-case detection, evaluated in IDLE.
  always_comb begin
    is_signed   = ~op[0];
    a_neg       = is_signed & dividend[XLEN-1];
    b_neg       = is_signed & divisor[XLEN-1];
    a_abs       = a_neg ? (~dividend + 1'b1) : dividend;
    b_abs       = b_neg ? (~divisor + 1'b1) : divisor;
    div_zero    = (divisor == '0);
    ovf         = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? dividend : '1;
    else if (!op[1])
      special_res = {1'b1, {(XLEN-1){1'b0}}};
  end

  // Restoring step: remainder stays below the divisor, so the difference fits XLEN bits.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_q};
    fits    = (shifted >= {1'b0, dvsr_q});
  end

  always_comb begin
    quo_fix   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    final_res = op_q[1] ? rem_fix : quo_fix;
  end

  assign busy = (state == S_CALC) || (state == S_FIXUP) || (start && (state == S_IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == S_DONE) && !flush;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              op_q <= op;
              if (div_zero || ovf) begin
                result <= special_res;
                state  <= S_DONE;
              end else begin
                rem_q     <= '0;
                quo_q     <= a_abs;
                dvsr_q    <= b_abs;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                cnt       <= CW'(ITERS);
                state     <= S_CALC;
              end
            end
          end
          S_CALC: begin
            rem_q <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], fits};
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1))
              state <= S_FIXUP;
          end
          S_FIXUP: begin
            result <= final_res;
            state  <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
// Stimulus pushes expected result, done cycle and busy run length; a negedge monitor checks them.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          due;
    int          busy_len;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   run_cur = 0;
  int   run_last = 0;

  localparam int LAT = 34;
  localparam int SLAT = 1;

  div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_cur = 0;
    end else begin
      if (done) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done=1 result=%h, required no done", result);
        end else begin
          exp_t e;
          e = q.pop_front();
          n_vec++;
          if (result !== e.res) begin
            n_err++; $display("FAIL result: got %h, required %h", result, e.res);
          end
          n_vec++;
          if (cyc != e.due) begin
            n_err++; $display("FAIL done_cycle: got %0d, required %0d", cyc, e.due);
          end
          n_vec++;
          if (run_last != e.busy_len) begin
            n_err++; $display("FAIL busy_len: got %0d, required %0d", run_last, e.busy_len);
          end
        end
      end
      if (busy) run_cur++;
      else begin
        if (run_cur != 0) run_last = run_cur;
        run_cur = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL timeout: got %0d pending results, required 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat, input bit hold);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; dividend = a; divisor = b;
    e.res = r; e.due = cyc + 1 + lat; e.busy_len = lat;
    q.push_back(e);
    repeat (hold ? lat : 1) @(posedge clk);
    #1 start = 1'b0;
    drain();
  endtask

  initial begin
    #12;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue(2'b00, 32'd100, 32'd7, 32'd14, LAT, 1'b0);
    issue(2'b10, 32'd100, 32'd7, 32'd2, LAT, 1'b0);
    issue(2'b00, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, LAT, 1'b0);
    issue(2'b10, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, LAT, 1'b0);
    issue(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFE, LAT, 1'b0);
    issue(2'b10, 32'd7, 32'hFFFFFFFD, 32'd1, LAT, 1'b0);
    issue(2'b00, 32'd5, 32'd0, 32'hFFFFFFFF, SLAT, 1'b0);
    issue(2'b11, 32'd5, 32'd0, 32'd5, SLAT, 1'b0);
    issue(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SLAT, 1'b0);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, SLAT, 1'b0);
    issue(2'b01, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, LAT, 1'b0);

    // Flush on the tenth CALC cycle: no done, result untouched.
    @(posedge clk); #1 start = 1'b1; op = 2'b00; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (2) @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_result", result, 32'h7FFFFFFF);
    repeat (40) @(negedge clk);
    issue(2'b00, 32'd9, 32'd3, 32'd3, LAT, 1'b0);

    // start held through CALC and the DONE cycle yields a single result.
    issue(2'b01, 32'd200, 32'd10, 32'd20, LAT, 1'b1);

    // Asynchronous reset in the middle of CALC.
    @(posedge clk); #1 start = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(2'b11, 32'd23, 32'd5, 32'd3, LAT, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
